// File: rtl/x2050_pkg.sv
// Shared S/360 program-check definitions: interruption codes, maskable codes and
// program-mask bit positions used by the program-check stage.
package x2050_pkg;

    localparam int NCODE_S360      = 15;

    localparam int PC_OPERATION    = 1;
    localparam int PC_PRIVILEGED   = 2;
    localparam int PC_EXECUTE      = 3;
    localparam int PC_PROTECTION   = 4;
    localparam int PC_ADDRESSING   = 5;
    localparam int PC_SPECIFICATION = 6;
    localparam int PC_DATA         = 7;
    localparam int PC_FIXED_OVF    = 8;
    localparam int PC_FIXED_DIVIDE = 9;
    localparam int PC_DEC_OVF      = 10;
    localparam int PC_DEC_DIVIDE   = 11;
    localparam int PC_EXP_OVF      = 12;
    localparam int PC_EXP_UNF      = 13;
    localparam int PC_SIGNIFICANCE = 14;
    localparam int PC_FP_DIVIDE    = 15;

    // Program-mask bit positions within the 4-bit mask.
    localparam int PM_FIXED_OVF    = 3;
    localparam int PM_DEC_OVF      = 2;
    localparam int PM_EXP_UNF      = 1;
    localparam int PM_SIGNIF       = 0;

    // Bit n-1 set means code n is subject to the program mask (codes 8,10,13,14).
    localparam logic [NCODE_S360-1:0] PC_MASKABLE = 15'h3280;

    // Per-code enable vector: unmaskable codes always enabled, maskable ones follow the mask.
    function automatic logic [NCODE_S360-1:0] pc_enable(input logic [3:0] pm);
        logic [NCODE_S360-1:0] en;
        en = ~PC_MASKABLE;
        en[PC_FIXED_OVF-1]    = pm[PM_FIXED_OVF];
        en[PC_DEC_OVF-1]      = pm[PM_DEC_OVF];
        en[PC_EXP_UNF-1]      = pm[PM_EXP_UNF];
        en[PC_SIGNIFICANCE-1] = pm[PM_SIGNIF];
        return en;
    endfunction

endpackage

// File: rtl/x2050pgenc.sv
// Lowest-set-bit priority encoder: bit i of the request vector maps to code i+1.
module x2050pgenc #(
    parameter int NCODE = 15
) (
    input  logic [NCODE-1:0] i_vec,
    output logic [3:0]       o_code,
    output logic             o_valid
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        o_code  = 4'd0;
        o_valid = 1'b0;
        for (int i = NCODE - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_code  = 4'(i + 1);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/x2050pgchk.sv
// Program-check latch, prioritised interruption code / ILC holding registers and
// branch-condition mask test against the current CC.
module x2050pgchk
    import x2050_pkg::*;
#(
    parameter int NCODE  = 15,
    parameter int CODE_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ros_advance,
    input  logic [1:0]        i_cc_reg,
    input  logic [3:0]        i_progmask,
    input  logic [NCODE-1:0]  i_pchk_set,
    input  logic [1:0]        i_ilc,
    input  logic              i_pgm_take,
    input  logic              i_pchk_clr,
    input  logic              i_bc_test,
    input  logic [3:0]        i_bc_mask,
    output logic              o_pgm_req,
    output logic [CODE_W-1:0] o_int_code,
    output logic [1:0]        o_ilc,
    output logic              o_bc_taken
);

    logic [NCODE-1:0]  r_pending;
    logic [CODE_W-1:0] r_int_code;
    logic [1:0]        r_ilc;
    logic              r_bc_taken;

    logic [NCODE-1:0]  w_enable;
    logic [NCODE-1:0]  w_set;
    logic              w_clr_all;
    logic              w_any_pend;
    logic              w_any_set;
    logic [3:0]        w_enc_code;
    logic              w_enc_valid;
    logic [1:0]        w_bc_sel;

    // Masking happens only here, at set time; pending bits ignore later mask changes.
    assign w_enable   = NCODE'(pc_enable(i_progmask));
    assign w_set      = i_pchk_set & w_enable;
    assign w_clr_all  = i_pgm_take | i_pchk_clr;
    assign w_any_pend = |r_pending;
    assign w_any_set  = |w_set;
    // 3 - cc for a 2-bit cc is its bitwise complement (M1 bit 3 tests CC0).
    assign w_bc_sel   = ~i_cc_reg;

    x2050pgenc #(.NCODE(NCODE)) u_enc (
        .i_vec   (r_pending),
        .o_code  (w_enc_code),
        .o_valid (w_enc_valid)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pending  <= '0;
            r_int_code <= '0;
            r_ilc      <= 2'd0;
            r_bc_taken <= 1'b0;
        end else if (i_ros_advance) begin
            r_pending <= (r_pending & ~{NCODE{w_clr_all}}) | w_set;
            if (i_pgm_take && w_enc_valid)
                r_int_code <= CODE_W'(w_enc_code);
            // A set arriving as the old batch is cleared starts a new batch with its own ILC.
            if (w_any_set && (!w_any_pend || w_clr_all))
                r_ilc <= i_ilc;
            if (i_bc_test)
                r_bc_taken <= i_bc_mask[w_bc_sel];
        end
    end

    assign o_pgm_req  = w_any_pend;
    assign o_int_code = r_int_code;
    assign o_ilc      = r_ilc;
    assign o_bc_taken = r_bc_taken;

endmodule

// File: tb/tb_x2050pgchk.sv
// Directed and randomized checks of x2050pgchk against a behavioural reference model.
module tb_x2050pgchk;

    logic        i_clk;
    logic        i_reset;
    logic        i_ros_advance;
    logic [1:0]  i_cc_reg;
    logic [3:0]  i_progmask;
    logic [14:0] i_pchk_set;
    logic [1:0]  i_ilc;
    logic        i_pgm_take;
    logic        i_pchk_clr;
    logic        i_bc_test;
    logic [3:0]  i_bc_mask;
    logic        o_pgm_req;
    logic [7:0]  o_int_code;
    logic [1:0]  o_ilc;
    logic        o_bc_taken;

    x2050pgchk #(.NCODE(15), .CODE_W(8)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_ros_advance (i_ros_advance),
        .i_cc_reg      (i_cc_reg),
        .i_progmask    (i_progmask),
        .i_pchk_set    (i_pchk_set),
        .i_ilc         (i_ilc),
        .i_pgm_take    (i_pgm_take),
        .i_pchk_clr    (i_pchk_clr),
        .i_bc_test     (i_bc_test),
        .i_bc_mask     (i_bc_mask),
        .o_pgm_req     (o_pgm_req),
        .o_int_code    (o_int_code),
        .o_ilc         (o_ilc),
        .o_bc_taken    (o_bc_taken)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: set of pending codes, plus the three holding values.
    bit [15:1] m_pend;
    int        m_code;
    int        m_ilc;
    bit        m_bc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit code_enabled(input int n, input logic [3:0] pm);
        case (n)
            8:       return pm[3];
            10:      return pm[2];
            13:      return pm[1];
            14:      return pm[0];
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_step();
        bit [15:1] nw;
        bit was;
        nw = '0;
        if (i_reset) begin
            m_pend = '0; m_code = 0; m_ilc = 0; m_bc = 0;
            return;
        end
        if (!i_ros_advance) return;
        for (int n = 1; n <= 15; n++)
            nw[n] = i_pchk_set[n-1] && code_enabled(n, i_progmask);
        was = (m_pend != 0);
        if (i_pgm_take && was) begin
            for (int n = 1; n <= 15; n++)
                if (m_pend[n]) begin m_code = n; break; end
        end
        if (nw != 0 && (!was || i_pgm_take || i_pchk_clr)) m_ilc = i_ilc;
        if (i_pgm_take || i_pchk_clr) m_pend = '0;
        m_pend |= nw;
        if (i_bc_test) m_bc = i_bc_mask[3 - i_cc_reg];
    endtask

    task automatic tick();
        model_step();
        @(posedge i_clk);
        #1;
        chk("pgm_req",  o_pgm_req,  (m_pend != 0));
        chk("int_code", o_int_code, m_code);
        chk("ilc",      o_ilc,      m_ilc);
        chk("bc_taken", o_bc_taken, m_bc);
    endtask

    task automatic drv(input logic [14:0] set, input logic take, input logic clr, input logic [1:0] ilc);
        i_reset = 1'b0; i_ros_advance = 1'b1; i_bc_test = 1'b0;
        i_pchk_set = set; i_pgm_take = take; i_pchk_clr = clr; i_ilc = ilc;
    endtask

    initial begin
        i_reset = 1'b1; i_ros_advance = 1'b1; i_cc_reg = 2'd3; i_progmask = 4'hF;
        i_pchk_set = 15'h7FFF; i_ilc = 2'd3; i_pgm_take = 1'b1; i_pchk_clr = 1'b0;
        i_bc_test = 1'b1; i_bc_mask = 4'hF;
        m_pend = '0; m_code = 0; m_ilc = 0; m_bc = 0;

        // Reset with all inputs active.
        tick();
        chk("rst_req", o_pgm_req, 0);
        chk("rst_code", o_int_code, 0);
        chk("rst_ilc", o_ilc, 0);
        chk("rst_bc", o_bc_taken, 0);

        // Specification exception, then take.
        i_progmask = 4'h0;
        drv(15'h0020, 1'b0, 1'b0, 2'd1); tick();
        chk("c6_req", o_pgm_req, 1);
        drv(15'h0000, 1'b1, 1'b0, 2'd0); tick();
        chk("c6_req_clr", o_pgm_req, 0);
        chk("c6_code", o_int_code, 8'h06);

        // Fixed-point overflow masked, then enabled.
        drv(15'h0080, 1'b0, 1'b0, 2'd1); tick();
        chk("c8_masked", o_pgm_req, 0);
        i_progmask = 4'h8;
        drv(15'h0080, 1'b0, 1'b0, 2'd1); tick();
        chk("c8_req", o_pgm_req, 1);
        drv(15'h0000, 1'b1, 1'b0, 2'd0); tick();
        chk("c8_code", o_int_code, 8'h08);

        // Codes 5 and 13 together: lowest wins, rest discarded.
        i_progmask = 4'h2;
        drv(15'h1010, 1'b0, 1'b0, 2'd2); tick();
        drv(15'h0000, 1'b1, 1'b0, 2'd0); tick();
        chk("c5_code", o_int_code, 8'h05);
        chk("c5_ilc", o_ilc, 2);
        chk("c5_clr", o_pgm_req, 0);

        // Take coinciding with a new set: old code reported, new ILC captured.
        drv(15'h0020, 1'b0, 1'b0, 2'd1); tick();
        drv(15'h0001, 1'b1, 1'b0, 2'd3); tick();
        chk("ovl_code", o_int_code, 8'h06);
        chk("ovl_req", o_pgm_req, 1);
        chk("ovl_ilc", o_ilc, 3);
        drv(15'h0000, 1'b1, 1'b0, 2'd0); tick();
        chk("ovl_code2", o_int_code, 8'h01);

        // Branch condition tests and advance gating.
        drv(15'h0000, 1'b0, 1'b0, 2'd0);
        i_bc_test = 1'b1; i_bc_mask = 4'b0010; i_cc_reg = 2'd2; tick();
        chk("bc_cc2", o_bc_taken, 1);
        i_cc_reg = 2'd1; tick();
        chk("bc_cc1", o_bc_taken, 0);
        i_cc_reg = 2'd2; i_ros_advance = 1'b0; i_pchk_set = 15'h0001; tick();
        chk("noadv_bc", o_bc_taken, 0);
        chk("noadv_req", o_pgm_req, 0);

        // Reset in the middle of pending work.
        drv(15'h0004, 1'b0, 1'b0, 2'd2); tick();
        i_reset = 1'b1; i_pgm_take = 1'b1; i_bc_test = 1'b1; i_bc_mask = 4'hF; tick();
        chk("mid_rst_req", o_pgm_req, 0);
        chk("mid_rst_code", o_int_code, 0);

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            logic [14:0] s;
            s = '0;
            for (int b = 0; b < 15; b++) s[b] = ($urandom_range(0, 9) == 0);
            i_reset       = ($urandom_range(0, 99) == 0);
            i_ros_advance = ($urandom_range(0, 4) != 0);
            i_cc_reg      = 2'($urandom);
            i_progmask    = 4'($urandom);
            i_pchk_set    = ($urandom_range(0, 2) == 0) ? s : 15'h0;
            i_ilc         = 2'($urandom);
            i_pgm_take    = ($urandom_range(0, 3) == 0);
            i_pchk_clr    = ($urandom_range(0, 15) == 0);
            i_bc_test     = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       i_bc_mask = 4'hF;
                1:       i_bc_mask = 4'h0;
                default: i_bc_mask = 4'($urandom);
            endcase
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
